tile_l15_req_arb: RTL and testbench

//  Shares the single L1.5 transducer request/response channel of a tile between

---
 rtl/tile_l15_req_arb.sv | 138 +++++++++++++
 tb/tb_tile_l15_req_arb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_l15_req_arb.sv
// Round-robin arbiter sharing one L1.5 transducer request/response channel
// among NREQ requesters, with exactly one transaction outstanding at a time.
module tile_l15_req_arb #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 40,
  parameter int AMO_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_val,
  input  logic [NREQ*5-1:0]        req_rqtype,
  input  logic [NREQ*AMO_W-1:0]    req_amo_op,
  input  logic [NREQ*3-1:0]        req_size,
  input  logic [NREQ*ADDR_W-1:0]   req_address,
  input  logic [NREQ*64-1:0]       req_data,
  input  logic [NREQ-1:0]          req_nc,
  output logic [NREQ-1:0]          req_hdr_ack,
  output logic [NREQ-1:0]          rsp_val,
  output logic [3:0]               rsp_returntype,
  output logic [63:0]              rsp_data_0,
  output logic [63:0]              rsp_data_1,
  output logic                     stray_rsp,
  output logic                     transducer_l15_val,
  output logic [4:0]               transducer_l15_rqtype,
  output logic [AMO_W-1:0]         transducer_l15_amo_op,
  output logic [2:0]               transducer_l15_size,
  output logic [ADDR_W-1:0]        transducer_l15_address,
  output logic [63:0]              transducer_l15_data,
  output logic                     transducer_l15_nc,
  input  logic                     l15_transducer_header_ack,
  input  logic                     l15_transducer_val,
  input  logic [3:0]               l15_transducer_returntype,
  input  logic [63:0]              l15_transducer_data_0,
  input  logic [63:0]              l15_transducer_data_1,
  output logic                     transducer_l15_req_ack
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: transducer_l15_val is held for the whole REQ phase and the
  // request is accepted in the cycle l15_transducer_header_ack is high; the
  // requester must hold req_val and its fields stable until its req_hdr_ack.
  // Responses are always consumed (req_ack mirrors l15_transducer_val).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   grant, grant_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   ptr_after_grant;
  logic            pick_ok;
  logic            hdr_hit;
  logic            rsp_hit;
  logic [NREQ-1:0] grant_oh;
  int              idx;

  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!pick_ok && req_val[idx]) begin
        pick    = IW'(idx);
        pick_ok = 1'b1;
      end
    end
  end

  assign ptr_after_grant = (int'(grant) == NREQ - 1) ? '0 : grant + IW'(1);
  assign grant_oh        = {{(NREQ-1){1'b0}}, 1'b1} << grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    hdr_hit    = 1'b0;
    rsp_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          grant_nxt = pick;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (l15_transducer_header_ack) begin
          hdr_hit    = 1'b1;
          rr_ptr_nxt = ptr_after_grant;
          // A response arriving with the header ack closes the transaction at once.
          rsp_hit    = l15_transducer_val;
          state_nxt  = l15_transducer_val ? IDLE : RESP;
        end
      end
      RESP: begin
        if (l15_transducer_val) begin
          rsp_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_hdr_ack            = hdr_hit ? grant_oh : '0;
  assign rsp_val                = rsp_hit ? grant_oh : '0;
  assign stray_rsp              = l15_transducer_val & ~rsp_hit;
  assign transducer_l15_req_ack = l15_transducer_val;

  assign rsp_returntype = l15_transducer_returntype;
  assign rsp_data_0     = l15_transducer_data_0;
  assign rsp_data_1     = l15_transducer_data_1;

  assign transducer_l15_val     = (state == REQ);
  assign transducer_l15_rqtype  = req_rqtype[int'(grant)*5 +: 5];
  assign transducer_l15_amo_op  = req_amo_op[int'(grant)*AMO_W +: AMO_W];
  assign transducer_l15_size    = req_size[int'(grant)*3 +: 3];
  assign transducer_l15_address = req_address[int'(grant)*ADDR_W +: ADDR_W];
  assign transducer_l15_data    = req_data[int'(grant)*64 +: 64];
  assign transducer_l15_nc      = req_nc[grant];

endmodule

// File: tb/tb_tile_l15_req_arb.sv
// Bench for tile_l15_req_arb: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_tile_l15_req_arb;
  localparam int NREQ   = 2;
  localparam int ADDR_W = 40;
  localparam int AMO_W  = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_val;
  logic [NREQ*5-1:0]      req_rqtype;
  logic [NREQ*AMO_W-1:0]  req_amo_op;
  logic [NREQ*3-1:0]      req_size;
  logic [NREQ*ADDR_W-1:0] req_address;
  logic [NREQ*64-1:0]     req_data;
  logic [NREQ-1:0]        req_nc;
  logic [NREQ-1:0]        req_hdr_ack;
  logic [NREQ-1:0]        rsp_val;
  logic [3:0]             rsp_returntype;
  logic [63:0]            rsp_data_0, rsp_data_1;
  logic                   stray_rsp;
  logic                   t_val;
  logic [4:0]             t_rqtype;
  logic [AMO_W-1:0]       t_amo_op;
  logic [2:0]             t_size;
  logic [ADDR_W-1:0]      t_address;
  logic [63:0]            t_data;
  logic                   t_nc;
  logic                   hack;
  logic                   l15v;
  logic [3:0]             l15_rtype;
  logic [63:0]            l15_d0, l15_d1;
  logic                   req_ack;

  tile_l15_req_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .AMO_W(AMO_W)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .req_val                   (req_val),
    .req_rqtype                (req_rqtype),
    .req_amo_op                (req_amo_op),
    .req_size                  (req_size),
    .req_address               (req_address),
    .req_data                  (req_data),
    .req_nc                    (req_nc),
    .req_hdr_ack               (req_hdr_ack),
    .rsp_val                   (rsp_val),
    .rsp_returntype            (rsp_returntype),
    .rsp_data_0                (rsp_data_0),
    .rsp_data_1                (rsp_data_1),
    .stray_rsp                 (stray_rsp),
    .transducer_l15_val        (t_val),
    .transducer_l15_rqtype     (t_rqtype),
    .transducer_l15_amo_op     (t_amo_op),
    .transducer_l15_size       (t_size),
    .transducer_l15_address    (t_address),
    .transducer_l15_data       (t_data),
    .transducer_l15_nc         (t_nc),
    .l15_transducer_header_ack (hack),
    .l15_transducer_val        (l15v),
    .l15_transducer_returntype (l15_rtype),
    .l15_transducer_data_0     (l15_d0),
    .l15_transducer_data_1     (l15_d1),
    .transducer_l15_req_ack    (req_ack)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard counters
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = free, 1 = request offered, 2 = awaiting response.
  // prio_q lists requesters in the order they are preferred for the next grant.
  int              m_phase = 0;
  int              m_owner = 0;
  int              prio_q[$];
  logic [NREQ-1:0] m_acked = '0;
  logic [NREQ-1:0] e_hack;
  logic [NREQ-1:0] e_rsp;

  function automatic void reset_prio();
    prio_q.delete();
    for (int k = 0; k < NREQ; k++) prio_q.push_back(k);
  endfunction

  task automatic eval();
    logic            done;
    logic [NREQ-1:0] one;
    #2;
    one   = 1;
    done  = l15v && ((m_phase == 2) || (m_phase == 1 && hack));
    e_hack = (m_phase == 1 && hack) ? (one << m_owner) : '0;
    e_rsp  = done ? (one << m_owner) : '0;
    check("val", 64'(t_val), 64'(m_phase == 1));
    if (m_phase == 1) begin
      check("addr",   64'(t_address), 64'(req_address[m_owner*ADDR_W +: ADDR_W]));
      check("data",   t_data,         req_data[m_owner*64 +: 64]);
      check("rqtype", 64'(t_rqtype),  64'(req_rqtype[m_owner*5 +: 5]));
      check("amo",    64'(t_amo_op),  64'(req_amo_op[m_owner*AMO_W +: AMO_W]));
      check("size",   64'(t_size),    64'(req_size[m_owner*3 +: 3]));
      check("nc",     64'(t_nc),      64'(req_nc[m_owner]));
    end
    check("hdr_ack", 64'(req_hdr_ack), 64'(e_hack));
    check("rsp_val", 64'(rsp_val),     64'(e_rsp));
    check("stray",   64'(stray_rsp),   64'(l15v && !done));
    check("req_ack", 64'(req_ack),     64'(l15v));
    check("rtype",   64'(rsp_returntype), 64'(l15_rtype));
    check("rsp_d0",  rsp_data_0, l15_d0);
    check("rsp_d1",  rsp_data_1, l15_d1);
  endtask

  task automatic tick();
    logic found;
    @(posedge clk);
    m_acked = e_hack;
    found   = 1'b0;
    if (rst) begin
      m_phase = 0;
      reset_prio();
    end else begin
      case (m_phase)
        0: begin
          for (int k = 0; k < prio_q.size(); k++) begin
            if (!found && req_val[prio_q[k]]) begin
              m_owner = prio_q[k];
              found   = 1'b1;
            end
          end
          if (found) m_phase = 1;
        end
        1: if (hack) begin
          prio_q.delete();
          for (int k = 0; k < NREQ; k++) prio_q.push_back((m_owner + 1 + k) % NREQ);
          m_phase = l15v ? 0 : 2;
        end
        default: if (l15v) m_phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic cyc();
    eval();
    tick();
  endtask

  logic [NREQ-1:0] pend;

  initial begin
    reset_prio();
    rst = 1'b1; req_val = 2'b11; hack = 1'b0; l15v = 1'b0;
    req_rqtype = '0; req_amo_op = '0; req_size = '0; req_address = '0;
    req_data = '0; req_nc = '0; l15_rtype = '0; l15_d0 = '0; l15_d1 = '0;
    @(posedge clk); #1;

    // reset held with both requesters asking
    for (int i = 0; i < 3; i++) begin
      eval();
      check("t1_val",   64'(t_val), 64'd0);
      check("t1_pulse", 64'({req_hdr_ack, rsp_val, stray_rsp}), 64'd0);
      tick();
    end

    // single request from requester 0
    rst = 1'b0; req_val = 2'b01;
    req_address[0 +: ADDR_W] = 40'h80_0000_1000;
    req_data[0 +: 64] = 64'h1234_5678_9abc_def0;
    eval(); check("t2_val_dly", 64'(t_val), 64'd0); tick();
    eval(); check("t2_val", 64'(t_val), 64'd1);
    check("t2_addr", 64'(t_address), 64'h80_0000_1000); tick();
    cyc(); cyc();
    hack = 1'b1;
    eval(); check("t2_hdr", 64'(req_hdr_ack), 64'h1); tick();
    hack = 1'b0; req_val = '0; l15v = 1'b1; l15_rtype = 4'h0; l15_d0 = 64'hDEAD;
    eval();
    check("t2_rsp", 64'(rsp_val), 64'h1);
    check("t2_ack", 64'(req_ack), 64'h1);
    check("t2_d0",  rsp_data_0,   64'hDEAD);
    tick();
    l15v = 1'b0;

    // fairness from reset with both requesters held
    rst = 1'b1; cyc(); rst = 1'b0;
    req_val = 2'b11;
    for (int t = 0; t < 4; t++) begin
      cyc();
      hack = 1'b1;
      eval(); check("t3_grant", 64'(req_hdr_ack), (t % 2 == 1) ? 64'h2 : 64'h1); tick();
      hack = 1'b0; l15v = 1'b1;
      cyc();
      l15v = 1'b0;
    end

    // header ack and response in the same cycle
    req_val = 2'b01;
    cyc();
    hack = 1'b1; l15v = 1'b1;
    eval();
    check("t4_hdr",   64'(req_hdr_ack), 64'h1);
    check("t4_rsp",   64'(rsp_val),     64'h1);
    check("t4_stray", 64'(stray_rsp),   64'h0);
    tick();
    hack = 1'b0; l15v = 1'b0; req_val = '0;
    eval(); check("t4_idle", 64'(t_val), 64'd0); tick();

    // stray response while idle
    l15v = 1'b1;
    eval();
    check("t5_stray", 64'(stray_rsp), 64'h1);
    check("t5_ack",   64'(req_ack),   64'h1);
    check("t5_rsp",   64'(rsp_val),   64'h0);
    tick();
    l15v = 1'b0;

    // reset while waiting for a response
    req_val = 2'b10;
    cyc();
    hack = 1'b1; cyc();
    hack = 1'b0; req_val = '0; rst = 1'b1; cyc();
    rst = 1'b0;
    eval(); check("t6_val", 64'(t_val), 64'd0); tick();
    l15v = 1'b1;
    eval();
    check("t6_stray", 64'(stray_rsp), 64'h1);
    check("t6_rsp",   64'(rsp_val),   64'h0);
    tick();
    l15v = 1'b0;

    // random traffic
    pend = '0; m_acked = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (m_acked[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          req_rqtype[i*5 +: 5]           = 5'($urandom());
          req_amo_op[i*AMO_W +: AMO_W]   = AMO_W'($urandom());
          req_size[i*3 +: 3]             = 3'($urandom());
          req_address[i*ADDR_W +: ADDR_W] = ADDR_W'({$urandom(), $urandom()});
          req_data[i*64 +: 64]           = {$urandom(), $urandom()};
          req_nc[i]                      = 1'($urandom());
        end
      end
      req_val   = pend;
      hack      = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      l15v      = (m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
      l15_rtype = 4'($urandom());
      l15_d0    = {$urandom(), $urandom()};
      l15_d1    = {$urandom(), $urandom()};
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
